// File: rtl/cda_match_index_fifo.sv
// Buffers legal CDA match indices in a first-word-fall-through FIFO with valid/ready output.
// Invalid encoder codes and overflow drops are tallied in saturating counters.
module cda_match_index_fifo #(
   parameter int IDX_WIDTH    = 7,
   parameter int DEPTH        = 8,
   parameter int INVALID_CODE = 127,
   parameter int MAX_INDEX    = 85,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [IDX_WIDTH-1:0]       in_index,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [IDX_WIDTH-1:0]       out_index,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic [CNT_WIDTH-1:0]       invalid_cnt,
   output logic [CNT_WIDTH-1:0]       overflow_cnt,
   input  logic                       clr_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [IDX_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]     level_reg, level_next;

   logic push_req, invalid_evt, pop, push_acc, overflow_evt;

   assign push_req     = in_valid && (in_index <= IDX_WIDTH'(MAX_INDEX));
   assign invalid_evt  = in_valid && !push_req;
   assign pop          = out_valid && out_ready;
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign push_acc     = push_req && (!full || pop);
   assign overflow_evt = push_req && !push_acc;

   assign level     = level_reg;
   assign full      = (level_reg == LVL_W'(DEPTH));
   assign empty     = (level_reg == '0);
   assign out_valid = !empty;
   assign out_index = empty ? IDX_WIDTH'(INVALID_CODE) : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wr_ptr_reg] <= in_index;
   end

   always_comb begin
      level_next = level_reg;
      if (push_acc && !pop)
         level_next = level_reg + 1'b1;
      else if (pop && !push_acc)
         level_next = level_reg - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_acc)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         level_reg <= level_next;
      end
   end

   logic [1:0]           cnt_evt;
   logic [CNT_WIDTH-1:0] cnt_reg [2];

   assign cnt_evt      = {overflow_evt, invalid_evt};
   assign invalid_cnt  = cnt_reg[0];
   assign overflow_cnt = cnt_reg[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         // Clear takes priority over a same-cycle event; counters hold at all-ones.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               cnt_reg[gi] <= '0;
            else if (clr_cnt)
               cnt_reg[gi] <= '0;
            else if (cnt_evt[gi] && (cnt_reg[gi] != '1))
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
         end
      end
   endgenerate

endmodule

// File: doc/cda_match_index_fifo.md
Name: cda_match_index_fifo

Overview:
- Downstream consumer of the CDA one-hot-to-binary match encoder.
- Each cycle the encoder is strobed, the block captures its 7-bit match index.
- Valid indices (0..85) are buffered in a small first-word-fall-through FIFO and presented to the order-execution logic over a valid/ready handshake.
- The encoder's invalid code (127: no match or multiple matches) is never stored; it is counted, as are indices dropped on overflow.

Parameters:
- IDX_WIDTH, 7, width of match index from encoder.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- INVALID_CODE, 127, encoder code meaning no/multiple match; never stored.
- MAX_INDEX, 85, highest legal index; values between MAX_INDEX+1 and INVALID_CODE-1 are treated as invalid.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  encoder en strobe; in_index sampled when high.
- in_index  input  IDX_WIDTH  encoder binary_out.
- out_valid  output  1  FIFO head holds a valid index.
- out_ready  input  1  consumer accepts head this cycle.
- out_index  output  IDX_WIDTH  FIFO head; equals INVALID_CODE when empty.
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- invalid_cnt  output  CNT_WIDTH  count of strobes carrying an invalid code.
- overflow_cnt  output  CNT_WIDTH  count of valid indices dropped because the FIFO was full.
- clr_cnt  input  1  synchronous clear of invalid_cnt and overflow_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and level = 0.
  - out_valid = 0, empty = 1, full = 0, out_index = INVALID_CODE.
  - Both counters = 0.
  - Storage array is not reset.
- Classification:
  - in_valid && in_index <= MAX_INDEX gives a legal push request.
  - in_valid && in_index > MAX_INDEX gives an invalid event.
  - in_valid low: no action.
- Pop: out_valid && out_ready.
  - rd_ptr advances modulo DEPTH.
  - out_valid is derived from the registered level, so pop is ignored when empty.
- Push:
  - A legal push request is accepted if level < DEPTH, or if level == DEPTH and a pop occurs in the same cycle.
  - On accept, the index is written at wr_ptr and wr_ptr advances modulo DEPTH.
  - A legal request that is not accepted is dropped and overflow_cnt increments.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency:
  - An index pushed at edge N appears on out_index with out_valid=1 after edge N.
  - Push into an empty FIFO: out_valid rises 1 cycle after the strobe cycle.
  - There is no same-cycle bypass from in_index to out_index.
- FWFT: out_index = mem[rd_ptr] whenever level > 0, otherwise INVALID_CODE. Ordering is strictly FIFO.
- Counters:
  - Increment by 1 per event and saturate at all-ones; no wrap.
  - clr_cnt high sets both to 0 at the next edge; clear wins over a same-cycle increment.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; full and empty come from level, not from pointer compare.
- Reset asserted mid-operation discards all contents immediately. First push after release behaves as into an empty FIFO.

Test Plan:
- Reset, then in_valid with index 5, 0, 85 on consecutive cycles, out_ready=1 -> out_index 5, 0, 85 in order, each 1 cycle after its strobe; level ends at 0; counters stay 0.
- in_valid with index 127, then 86, then 100 -> nothing stored, empty stays 1, invalid_cnt = 3, out_index = 127.
- out_ready=0, push 10 indices 1..10 with DEPTH=8 -> full=1, level=8, overflow_cnt=2; then drain with out_ready=1 -> out_index 1..8, then empty.
- FIFO full with out_ready=1 and a push of 42 in the same cycle -> push accepted, level stays 8, overflow_cnt unchanged, 42 emerges last.
- Force invalid_cnt to all-ones via 65536+ invalid strobes (CNT_WIDTH=16), then more -> holds 65535. Then clr_cnt together with an invalid strobe -> invalid_cnt = 0.
- Push 3 indices, assert rst_n low mid-cycle -> out_valid=0 and level=0 immediately. After release, push 7 -> out_index=7 next cycle.
